aes_key_schedule_ctrl: RTL

- Sequencer for the AES-128 key expansion datapath.
- Accepts the cipher key byte-serially, most significant byte first.
- Generates round keys 0..NR one round at a time, sharing a single external byte-wide S-box port.
- Hands each round key to the round datapath over a valid/ready handshake.

---
 rtl/aes_key_schedule_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_ctrl
//
// Sequencer for the AES-128 key expansion datapath. The cipher key arrives
// byte-serially (MSB first). Round keys 0..NR are produced one round at a
// time. A single external byte-wide S-box port is shared across the four
// SubWord lookups of each round. Each round key is offered to the round
// datapath over a valid/ready handshake.
//
// Optional feature macro: KEY_SCHED_STORE_EN
//   When defined, every round key is also written into an internal store at
//   its handshake. A replay pulse in IDLE, after a completed key, re-emits
//   the stored keys. The order is forward (0..NR) or reverse (NR..0), and no
//   S-box lookups are made. Loading a new key or reset invalidates the store.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   key_byte_valid  key byte present
//   key_byte[7:0]   key byte; first accepted byte lands in key[127:120]
//   key_byte_ready  block can accept a key byte (IDLE/LOAD)
//   rk_valid        rk_data/rk_round valid
//   rk_ready        consumer accepts the round key
//   rk_data[127:0]  current round key
//   rk_round[3:0]   index of the round key, 0..NR
//   busy            high in every state except IDLE
//   done            one-cycle pulse after round key NR is accepted
//   replay          (KEY_SCHED_STORE_EN only) start replay from IDLE
//   replay_rev      (KEY_SCHED_STORE_EN only) replay order NR..0 when high
//   sbox_in[7:0]    S-box lookup byte (0 outside SUB)
//   sbox_out[7:0]   S-box result, combinational from sbox_in
// -----------------------------------------------------------------------------
module aes_key_schedule_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_byte_valid,
    input  logic [7:0]   key_byte,
    output logic         key_byte_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done,
`ifdef KEY_SCHED_STORE_EN
    input  logic         replay,
    input  logic         replay_rev,
`endif
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        SUB,
        XOR,
`ifdef KEY_SCHED_STORE_EN
        RPLY,
`endif
        FIN
    } state_t;

    state_t         state;
    state_t         state_n;

    logic [127:0]   key_q;
    logic [3:0]     byte_cnt;
    logic [1:0]     sub_idx;
    logic [31:0]    temp_q;
    logic [7:0]     rcon_q;
    logic [3:0]     round_q;

    logic [31:0]    rot_word;
    logic [31:0]    temp_rc;
    logic [31:0]    w0_n;
    logic [31:0]    w1_n;
    logic [31:0]    w2_n;
    logic [31:0]    w3_n;
    logic [7:0]     rcon_next;

`ifdef KEY_SCHED_STORE_EN
    logic [127:0]   store [0:NR];
    logic           store_valid;
    logic           rev_q;
    logic           replay_last;
`endif

    // RotWord of w3 = key[31:0]: bytes w3[23:16], w3[15:8], w3[7:0], w3[31:24].
    assign rot_word  = {key_q[23:0], key_q[31:24]};

    // Next round key words; each word chains off the freshly computed previous one.
    assign temp_rc   = temp_q ^ {rcon_q, 24'h0};
    assign w0_n      = key_q[127:96] ^ temp_rc;
    assign w1_n      = key_q[95:64]  ^ w0_n;
    assign w2_n      = key_q[63:32]  ^ w1_n;
    assign w3_n      = key_q[31:0]   ^ w2_n;

    // xtime in GF(2^8): 8'h80 wraps to 8'h1b.
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    assign rk_round  = round_q;

`ifdef KEY_SCHED_STORE_EN
    assign replay_last = rev_q ? (round_q == 4'd0) : (round_q == LAST_ROUND);
    assign rk_data     = (state == RPLY) ? store[round_q] : key_q;
`else
    assign rk_data     = key_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is written with non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_n        = state;
        key_byte_ready = 1'b0;
        rk_valid       = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        sbox_in        = 8'h00;

        case (state)
            IDLE: begin
                busy           = 1'b0;
                key_byte_ready = 1'b1;
                if (key_byte_valid) begin
                    state_n = LOAD;
                end
`ifdef KEY_SCHED_STORE_EN
                else if (replay && store_valid) begin
                    state_n = RPLY;
                end
`endif
            end
            LOAD: begin
                key_byte_ready = 1'b1;
                if (key_byte_valid && byte_cnt == 4'd15) begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    state_n = (round_q == LAST_ROUND) ? FIN : SUB;
                end
            end
            SUB: begin
                case (sub_idx)
                    2'd0:    sbox_in = rot_word[31:24];
                    2'd1:    sbox_in = rot_word[23:16];
                    2'd2:    sbox_in = rot_word[15:8];
                    default: sbox_in = rot_word[7:0];
                endcase
                if (sub_idx == 2'd3) begin
                    state_n = XOR;
                end
            end
            XOR: begin
                state_n = EMIT;
            end
`ifdef KEY_SCHED_STORE_EN
            RPLY: begin
                rk_valid = 1'b1;
                if (rk_ready && replay_last) begin
                    state_n = FIN;
                end
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Key, counters and round constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= '0;
            byte_cnt <= 4'd0;
            sub_idx  <= 2'd0;
            temp_q   <= '0;
            rcon_q   <= 8'h01;
            round_q  <= 4'd0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (key_byte_valid) begin
                        key_q    <= {key_q[119:0], key_byte};
                        // Wraps to 0 on the 16th byte, ready for the next key.
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd15) begin
                            round_q <= 4'd0;
                            rcon_q  <= 8'h01;
                        end
                    end
`ifdef KEY_SCHED_STORE_EN
                    else if (state == IDLE && replay && store_valid) begin
                        round_q <= replay_rev ? LAST_ROUND : 4'd0;
                    end
`endif
                end
                SUB: begin
                    // Shifting in keeps lookup 0 in the top byte after four cycles.
                    temp_q  <= {temp_q[23:0], sbox_out};
                    sub_idx <= sub_idx + 2'd1;
                end
                XOR: begin
                    key_q   <= {w0_n, w1_n, w2_n, w3_n};
                    round_q <= round_q + 4'd1;
                    rcon_q  <= rcon_next;
                end
`ifdef KEY_SCHED_STORE_EN
                RPLY: begin
                    if (rk_ready && !replay_last) begin
                        round_q <= rev_q ? (round_q - 4'd1) : (round_q + 4'd1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef KEY_SCHED_STORE_EN
    // NOTE: the key store has no reset; store_valid alone decides whether its
    // contents may be replayed, which keeps the array a plain memory.
    always_ff @(posedge clk) begin
        if (state == EMIT && rk_ready) begin
            store[round_q] <= key_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_valid <= 1'b0;
            rev_q       <= 1'b0;
        end else begin
            if (key_byte_valid && key_byte_ready) begin
                store_valid <= 1'b0;
            end else if (state == EMIT && rk_ready && round_q == LAST_ROUND) begin
                store_valid <= 1'b1;
            end
            if (state == IDLE && !key_byte_valid && replay && store_valid) begin
                rev_q <= replay_rev;
            end
        end
    end
`endif

endmodule
